// File: rtl/jt5205_pkg.sv
// Shared constants for the MSM5205 ADPCM decoder: step table, index
// adjustment table, index limit and decoder FSM states.
package jt5205_pkg;

    localparam int IDX_MAX = 48;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOK = 2'd1,
        ST_ACC  = 2'd2
    } adpcm_state_t;

    // OKI step size for each of the 49 index positions
    function automatic logic [11:0] step_lut(input logic [5:0] idx);
        logic [11:0] s;
        case (idx)
            6'd0:  s = 12'd16;   6'd1:  s = 12'd17;   6'd2:  s = 12'd19;
            6'd3:  s = 12'd21;   6'd4:  s = 12'd23;   6'd5:  s = 12'd25;
            6'd6:  s = 12'd28;   6'd7:  s = 12'd31;   6'd8:  s = 12'd34;
            6'd9:  s = 12'd37;   6'd10: s = 12'd41;   6'd11: s = 12'd45;
            6'd12: s = 12'd50;   6'd13: s = 12'd55;   6'd14: s = 12'd60;
            6'd15: s = 12'd66;   6'd16: s = 12'd73;   6'd17: s = 12'd80;
            6'd18: s = 12'd88;   6'd19: s = 12'd97;   6'd20: s = 12'd107;
            6'd21: s = 12'd118;  6'd22: s = 12'd130;  6'd23: s = 12'd143;
            6'd24: s = 12'd157;  6'd25: s = 12'd173;  6'd26: s = 12'd190;
            6'd27: s = 12'd209;  6'd28: s = 12'd230;  6'd29: s = 12'd253;
            6'd30: s = 12'd279;  6'd31: s = 12'd307;  6'd32: s = 12'd337;
            6'd33: s = 12'd371;  6'd34: s = 12'd408;  6'd35: s = 12'd449;
            6'd36: s = 12'd494;  6'd37: s = 12'd544;  6'd38: s = 12'd598;
            6'd39: s = 12'd658;  6'd40: s = 12'd724;  6'd41: s = 12'd796;
            6'd42: s = 12'd876;  6'd43: s = 12'd963;  6'd44: s = 12'd1060;
            6'd45: s = 12'd1166; 6'd46: s = 12'd1282; 6'd47: s = 12'd1411;
            // index never exceeds 48; anything above maps to the top step
            default: s = 12'd1552;
        endcase
        return s;
    endfunction

    // Index adjustment from the magnitude bits of the nibble
    function automatic logic signed [7:0] adj_lut(input logic [2:0] mag);
        logic signed [7:0] a;
        case (mag)
            3'd4:    a = 8'sd2;
            3'd5:    a = 8'sd4;
            3'd6:    a = 8'sd6;
            3'd7:    a = 8'sd8;
            default: a = -8'sd1;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/jt5205_steps.sv
// Registered step-size ROM: idx -> step, one-cycle read.
module jt5205_steps
    import jt5205_pkg::*;
(
    input  logic        clk,
    input  logic        en,
    input  logic [5:0]  idx,
    output logic [11:0] step
);

    logic [11:0] r_step;

    // load a new step only when the decoder asks for one
    always_ff @(posedge clk) begin
        if (en) r_step <= step_lut(idx);
    end

    assign step = r_step;

endmodule

// File: rtl/jt5205_adpcm.sv
// MSM5205 4-bit ADPCM decoder: nibble latch, step lookup, accumulate
// with clamp, step-index adaptation.
module jt5205_adpcm
    import jt5205_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        sample_en,
    input  logic [3:0]  din,
    input  logic        pcm_rst,
    output logic [11:0] sound,
    output logic        sound_vld,
    output logic        drop
);

    adpcm_state_t      r_state;
    logic [3:0]        r_nib;
    logic [5:0]        r_idx;
    logic [11:0]       r_sound;
    logic              r_vld;
    logic              r_drop;

    logic [11:0]       w_step;
    logic              w_rom_en;
    logic [12:0]       w_delta;
    logic signed [13:0] w_acc;
    logic signed [13:0] w_dlt;
    logic signed [13:0] w_sum;
    logic [11:0]       w_sound_nxt;
    logic signed [7:0] w_idx_sum;
    logic [5:0]        w_idx_nxt;

    // step is fetched during LOOK so it is stable for the ACC edge
    assign w_rom_en = cen & ~pcm_rst & (r_state == ST_LOOK);

    jt5205_steps u_steps (
        .clk  (clk),
        .en   (w_rom_en),
        .idx  (r_idx),
        .step (w_step)
    );

    // delta from the magnitude bits, signed sum and clamp to 12 bits
    always_comb begin
        w_delta = {4'd0, w_step[11:3]};
        if (r_nib[2]) w_delta = w_delta + {1'b0, w_step};
        if (r_nib[1]) w_delta = w_delta + {2'd0, w_step[11:1]};
        if (r_nib[0]) w_delta = w_delta + {3'd0, w_step[11:2]};
        w_acc = {{2{r_sound[11]}}, r_sound};
        w_dlt = {1'b0, w_delta};
        w_sum = r_nib[3] ? (w_acc - w_dlt) : (w_acc + w_dlt);
        if (w_sum > 14'sd2047)       w_sound_nxt = 12'h7FF;
        else if (w_sum < -14'sd2048) w_sound_nxt = 12'h800;
        else                         w_sound_nxt = w_sum[11:0];
    end

    // step-index adaptation saturated to the table range
    always_comb begin
        w_idx_sum = $signed({2'b00, r_idx}) + adj_lut(r_nib[2:0]);
        if (w_idx_sum < 8'sd0)                  w_idx_nxt = 6'd0;
        else if (w_idx_sum > 8'(IDX_MAX))       w_idx_nxt = 6'(IDX_MAX);
        else                                    w_idx_nxt = w_idx_sum[5:0];
    end

    // decoder FSM: IDLE captures, LOOK fetches step, ACC updates outputs
    always_ff @(posedge clk) begin
        r_vld <= 1'b0;
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_nib   <= 4'd0;
            r_idx   <= 6'd0;
            r_sound <= 12'd0;
            r_drop  <= 1'b0;
        end else if (cen) begin
            if (pcm_rst) begin
                // chip RESET pin: abandon decode, keep the drop flag
                r_state <= ST_IDLE;
                r_idx   <= 6'd0;
                r_sound <= 12'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (sample_en) begin
                            r_nib   <= din;
                            r_state <= ST_LOOK;
                        end
                    end
                    ST_LOOK: begin
                        if (sample_en) r_drop <= 1'b1;
                        r_state <= ST_ACC;
                    end
                    ST_ACC: begin
                        if (sample_en) r_drop <= 1'b1;
                        r_sound <= w_sound_nxt;
                        r_idx   <= w_idx_nxt;
                        r_vld   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign sound     = r_sound;
    assign sound_vld = r_vld;
    assign drop      = r_drop;

endmodule

// File: tb/tb_jt5205_adpcm.sv
// Randomized self-checking bench for jt5205_adpcm against an arithmetic
// reference model of the OKI ADPCM decode rules.
module tb_jt5205_adpcm;

    logic        clk = 1'b0;
    logic        rst_n, cen, sample_en, pcm_rst;
    logic [3:0]  din;
    logic [11:0] sound;
    logic        sound_vld, drop;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int m_sound, m_idx;
    bit m_drop;

    int STEP_T [49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,
                        88,97,107,118,130,143,157,173,190,209,230,253,279,307,
                        337,371,408,449,494,544,598,658,724,796,876,963,1060,
                        1166,1282,1411,1552};

    jt5205_adpcm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .sample_en (sample_en),
        .din       (din),
        .pcm_rst   (pcm_rst),
        .sound     (sound),
        .sound_vld (sound_vld),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dut_sound();
        return int'($signed(sound));
    endfunction

    // model: one nibble through the decode rules
    task automatic model_apply(input logic [3:0] nib);
        int st, d, s, a;
        st = STEP_T[m_idx];
        d  = st / 8;
        if (nib[2]) d += st;
        if (nib[1]) d += st / 2;
        if (nib[0]) d += st / 4;
        s = nib[3] ? m_sound - d : m_sound + d;
        if (s > 2047)  s = 2047;
        if (s < -2048) s = -2048;
        m_sound = s;
        case (nib[2:0])
            3'd4: a = 2;  3'd5: a = 4;  3'd6: a = 6;  3'd7: a = 8;
            default: a = -1;
        endcase
        m_idx += a;
        if (m_idx < 0)  m_idx = 0;
        if (m_idx > 48) m_idx = 48;
    endtask

    task automatic cyc(input logic c, input logic se, input logic [3:0] d,
                       input logic pr);
        cen = c; sample_en = se; din = d; pcm_rst = pr;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 1'b1, 4'd7, 1'b0);
        cyc(1'b1, 1'b1, 4'd7, 1'b0);
        rst_n = 1'b1;
        m_sound = 0; m_idx = 0; m_drop = 0;
    endtask

    task automatic do_pcm_rst();
        cyc(1'b1, 1'b1, 4'($urandom), 1'b1);
        m_sound = 0; m_idx = 0;
    endtask

    // send one nibble; random cen gaps; optional busy strobe right after capture
    task automatic decode(input logic [3:0] nib, input bit busy);
        int ncen, k;
        bit seen;
        logic c, se;
        ncen = 0; seen = 0; k = 0;
        cyc(1'b1, 1'b1, nib, 1'b0);
        chk("vld_capture", int'(sound_vld), 0);
        while (!seen && k < 40) begin
            if (busy && k == 0) begin
                c = 1'b1; se = 1'b1;
            end else begin
                c  = 1'($urandom_range(0, 2) != 0);
                se = c ? 1'b0 : 1'($urandom);
            end
            cyc(c, se, 4'($urandom), 1'b0);
            if (c) ncen++;
            if (sound_vld) seen = 1;
            else if (ncen >= 2) k = 40;
            k++;
        end
        model_apply(nib);
        if (busy) m_drop = 1;
        chk("vld_seen", int'(seen), 1);
        chk("latency", ncen, 2);
        chk("sound", dut_sound(), m_sound);
        chk("drop", int'(drop), int'(m_drop));
        cyc(1'($urandom), 1'b0, 4'd0, 1'b0);
        chk("vld_one_clk", int'(sound_vld), 0);
    endtask

    initial begin
        int prev;
        rst_n = 1'b1; cen = 1'b0; sample_en = 1'b0; din = 4'd0; pcm_rst = 1'b0;

        // reset with a live strobe on the inputs
        do_reset();
        chk("rst_sound", dut_sound(), 0);
        chk("rst_vld", int'(sound_vld), 0);
        chk("rst_drop", int'(drop), 0);

        // directed pair from reset: 30 then -33
        decode(4'b0111, 0);
        chk("dir_30", dut_sound(), 30);
        decode(4'b1111, 0);
        chk("dir_m33", dut_sound(), -33);

        // positive clamp, monotonic rise, then negative clamp
        do_pcm_rst();
        chk("pcm_rst_sound", dut_sound(), 0);
        prev = 0;
        for (int i = 0; i < 30; i++) begin
            decode(4'b0111, 0);
            chk("mono_up", int'(dut_sound() >= prev), 1);
            prev = dut_sound();
        end
        chk("clamp_hi", dut_sound(), 2047);
        for (int i = 0; i < 30; i++) decode(4'b1111, 0);
        chk("clamp_lo", dut_sound(), -2048);

        // index floor
        do_reset();
        for (int i = 0; i < 3; i++) begin
            decode(4'b0000, 0);
            chk("floor", dut_sound(), 2 * (i + 1));
        end

        // busy drop: second strobe ignored, flag sticky through pcm_rst
        decode(4'b0101, 1);
        do_pcm_rst();
        chk("drop_sticky", int'(drop), 1);
        do_reset();
        chk("drop_cleared", int'(drop), 0);

        // pcm_rst while in LOOK abandons the decode
        decode(4'b0110, 0);
        cyc(1'b1, 1'b1, 4'b0111, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 1'b1);
        m_sound = 0; m_idx = 0;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 4'd0, 1'b0);
            if (sound_vld) prev = 1;
        end
        chk("abort_no_vld", prev, 0);
        chk("abort_sound", dut_sound(), 0);
        decode(4'b0111, 0);
        chk("abort_redecode", dut_sound(), 30);

        // pcm_rst beats a simultaneous strobe
        cyc(1'b1, 1'b1, 4'b0111, 1'b1);
        m_sound = 0; m_idx = 0;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 4'd0, 1'b0);
            if (sound_vld) prev = 1;
        end
        chk("pcm_wins", prev, 0);

        // random nibble stream with occasional pcm_rst and busy strobes
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) do_pcm_rst();
            decode(4'($urandom), $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
